// File: rtl/riscv_dmem_ctrl_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings and FSM states.
package riscv_dmem_ctrl_pkg;

    // func3[1:0] access-size encodings
    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;
    localparam logic [1:0] MEM_SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        RESP  = 2'b10,
        DRAIN = 2'b11
    } dmem_state_t;

    // Byte mask for an access of the given size, before lane shifting
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            MEM_SIZE_B: size_mask = 8'h01;
            MEM_SIZE_H: size_mask = 8'h03;
            MEM_SIZE_W: size_mask = 8'h0F;
            default:    size_mask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/riscv_dmem_ctrl_if.sv
// Pipeline-side request/response and data-bus signals of the data-memory responder.
interface riscv_dmem_ctrl_if #(
    parameter int XLEN = 32
);
    logic                mem_req_i;
    logic                mem_we_i;
    logic [2:0]          mem_size_i;
    logic [XLEN-1:0]     mem_adr_i;
    logic [XLEN-1:0]     mem_d_i;
    logic                flush_i;
    logic                dmem_ack_o;
    logic                dmem_err_o;
    logic                dmem_misaligned_o;
    logic                dmem_page_fault_o;
    logic [XLEN-1:0]     dmem_q_o;
    logic                bus_req_o;
    logic                bus_we_o;
    logic [XLEN-1:0]     bus_adr_o;
    logic [XLEN/8-1:0]   bus_be_o;
    logic [XLEN-1:0]     bus_d_o;
    logic                bus_ack_i;
    logic                bus_err_i;
    logic [XLEN-1:0]     bus_q_i;

    // controller view
    modport slave (
        input  mem_req_i, mem_we_i, mem_size_i, mem_adr_i, mem_d_i, flush_i,
        output dmem_ack_o, dmem_err_o, dmem_misaligned_o, dmem_page_fault_o, dmem_q_o,
        output bus_req_o, bus_we_o, bus_adr_o, bus_be_o, bus_d_o,
        input  bus_ack_i, bus_err_i, bus_q_i
    );

    // pipeline + bus environment view
    modport master (
        output mem_req_i, mem_we_i, mem_size_i, mem_adr_i, mem_d_i, flush_i,
        input  dmem_ack_o, dmem_err_o, dmem_misaligned_o, dmem_page_fault_o, dmem_q_o,
        input  bus_req_o, bus_we_o, bus_adr_o, bus_be_o, bus_d_o,
        output bus_ack_i, bus_err_i, bus_q_i
    );

endinterface

// File: rtl/riscv_dmem_ctrl_align.sv
// Combinational access checker: alignment, range/size legality, byte lanes and lane-shifted data.
module riscv_dmem_align
    import riscv_dmem_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] MEM_BASE = 'h0,
    parameter logic [XLEN-1:0] MEM_SIZE = 'h10000
) (
    input  logic [2:0]        size_i,
    input  logic [XLEN-1:0]   adr_i,
    input  logic [XLEN-1:0]   d_i,
    output logic              misaligned_o,
    output logic              range_err_o,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   d_o,
    output logic [XLEN-1:0]   adr_o
);
    localparam int BEW  = XLEN / 8;
    localparam int OFFW = $clog2(BEW);

    logic [OFFW-1:0] off;
    logic [XLEN:0]   adr_ext;
    logic [XLEN:0]   lim_ext;
    logic            unused_size_msb;

    // unsigned flag only matters to write-back sign extension
    assign unused_size_msb = size_i[2];
    assign off     = adr_i[OFFW-1:0];
    // one extra bit so MEM_BASE+MEM_SIZE cannot wrap
    assign adr_ext = {1'b0, adr_i};
    assign lim_ext = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    // Classify the access and build the lane-aligned bus fields
    always_comb begin
        misaligned_o = 1'b0;
        case (size_i[1:0])
            MEM_SIZE_H: misaligned_o = adr_i[0];
            MEM_SIZE_W: misaligned_o = |adr_i[1:0];
            MEM_SIZE_D: misaligned_o = |adr_i[2:0];
            default:    misaligned_o = 1'b0;
        endcase
        range_err_o = (adr_ext < {1'b0, MEM_BASE}) || (adr_ext >= lim_ext)
                   || ((size_i[1:0] == MEM_SIZE_D) && (XLEN == 32));
        be_o  = BEW'(size_mask(size_i[1:0])) << off;
        d_o   = d_i << {off, 3'b000};
        adr_o = {adr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
    end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Data-memory responder: accepts one MEM-stage access, runs the bus cycle, returns a one-cycle response.
//
// state | meaning
// IDLE  | waiting for a request from the pipeline
// BUSY  | bus cycle in flight, bus fields held
// RESP  | one-cycle response pulse to write-back
// DRAIN | flushed access still on the bus; result discarded
module riscv_dmem_ctrl
    import riscv_dmem_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] MEM_BASE = 'h0,
    parameter logic [XLEN-1:0] MEM_SIZE = 'h10000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    riscv_dmem_ctrl_if.slave dmem
);
    localparam int BEW = XLEN / 8;

    dmem_state_t     state_q, state_d;
    logic            a_mis, a_rerr;
    logic [BEW-1:0]  a_be;
    logic [XLEN-1:0] a_d, a_adr;
    logic            accept, done;

    logic            bus_req_q, bus_req_d, bus_we_q, bus_we_d;
    logic [XLEN-1:0] bus_adr_q, bus_adr_d, bus_d_q, bus_d_d;
    logic [BEW-1:0]  bus_be_q, bus_be_d;
    logic            ack_q, ack_d, err_q, err_d, mis_q, mis_d;
    logic [XLEN-1:0] q_q, q_d;

    riscv_dmem_align #(
        .XLEN     (XLEN),
        .MEM_BASE (MEM_BASE),
        .MEM_SIZE (MEM_SIZE)
    ) u_align (
        .size_i       (dmem.mem_size_i),
        .adr_i        (dmem.mem_adr_i),
        .d_i          (dmem.mem_d_i),
        .misaligned_o (a_mis),
        .range_err_o  (a_rerr),
        .be_o         (a_be),
        .d_o          (a_d),
        .adr_o        (a_adr)
    );

    assign accept = dmem.mem_req_i && !dmem.flush_i;
    assign done   = dmem.bus_ack_i || dmem.bus_err_i;

    // State and all registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            bus_adr_q <= '0;
            bus_be_q  <= '0;
            bus_d_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            q_q       <= '0;
        end else begin
            state_q   <= state_d;
            bus_req_q <= bus_req_d;
            bus_we_q  <= bus_we_d;
            bus_adr_q <= bus_adr_d;
            bus_be_q  <= bus_be_d;
            bus_d_q   <= bus_d_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
            q_q       <= q_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (a_mis || a_rerr) ? RESP : BUSY;
            BUSY: begin
                if (done) state_d = dmem.flush_i ? IDLE : RESP;
                else if (dmem.flush_i) state_d = DRAIN;
            end
            DRAIN:   if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of bus fields and response pulse; response bits only live for the RESP cycle
    always_comb begin
        bus_req_d = bus_req_q;
        bus_we_d  = bus_we_q;
        bus_adr_d = bus_adr_q;
        bus_be_d  = bus_be_q;
        bus_d_d   = bus_d_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        mis_d     = 1'b0;
        q_d       = q_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (a_mis) begin
                        mis_d = 1'b1;
                    end else if (a_rerr) begin
                        err_d = 1'b1;
                    end else begin
                        bus_req_d = 1'b1;
                        bus_we_d  = dmem.mem_we_i;
                        bus_adr_d = a_adr;
                        bus_be_d  = a_be;
                        bus_d_d   = a_d;
                    end
                end
            end
            BUSY: begin
                if (done) begin
                    bus_req_d = 1'b0;
                    if (!dmem.flush_i) begin
                        if (dmem.bus_err_i) begin
                            err_d = 1'b1;
                        end else begin
                            ack_d = 1'b1;
                            q_d   = bus_we_q ? '0 : dmem.bus_q_i;
                        end
                    end
                end
            end
            DRAIN:   if (done) bus_req_d = 1'b0;
            default: ;
        endcase
    end

    assign dmem.bus_req_o         = bus_req_q;
    assign dmem.bus_we_o          = bus_we_q;
    assign dmem.bus_adr_o         = bus_adr_q;
    assign dmem.bus_be_o          = bus_be_q;
    assign dmem.bus_d_o           = bus_d_q;
    assign dmem.dmem_ack_o        = ack_q;
    assign dmem.dmem_err_o        = err_q;
    assign dmem.dmem_misaligned_o = mis_q;
    assign dmem.dmem_page_fault_o = 1'b0;
    assign dmem.dmem_q_o          = q_q;

endmodule
